// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: round-robin sharing of one synchronous ROM port among NUM_REQ requesters
module rom_access_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                          in_clk,
  input  logic                          in_rst_p,
  input  logic [NUM_REQ-1:0]            in_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] in_addr,
  output logic [NUM_REQ-1:0]            out_ack,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_grant_id,
  output logic                          out_busy,
  output logic [ADDR_WIDTH-1:0]         out_rom_addr,
  input  logic [DATA_WIDTH-1:0]         in_rom_data
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ROM_LATENCY + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [GW-1:0]         winner, idx;
  logic                  found;
  // first requester at or after last_grant+1, wrapping
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found && in_req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack_d   = '0;
    data_d  = data_q;
    case (state_q)
      IDLE: if (found) begin
        addr_d  = in_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        grant_d = winner;
        cnt_d   = CW'(ROM_LATENCY);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == '0) begin
        data_d  = in_rom_data;
        ack_d   = NUM_REQ'(1) << grant_q;
        last_d  = grant_q;
        state_d = ACK;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge in_clk) begin
    if (in_rst_p) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      ack_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end
  assign out_ack      = ack_q;
  assign out_data     = data_q;
  assign out_grant_id = grant_q;
  assign out_busy     = state_q != IDLE;
  assign out_rom_addr = addr_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: table vectors plus corner sequences, ack/data checked via scoreboard queues
module tb_rom_access_arbiter;
  typedef struct {
    logic [2:0] ack;
    logic [7:0] data;
  } exp_t;
  typedef struct {
    logic [1:0]  req;
    logic [15:0] a0;
    logic [15:0] a1;
    logic        g;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0]  req_a = '0;
  logic [31:0] addr_a = '0;
  logic [1:0]  ack_a;
  logic [7:0]  data_a, rom_data_a;
  logic        grant_a, busy_a;
  logic [15:0] rom_addr_a;
  logic [2:0]  req_b = '0;
  logic [47:0] addr_b = '0;
  logic [2:0]  ack_b;
  logic [7:0]  data_b, rom_data_b, rb1, rb2;
  logic [1:0]  grant_b;
  logic        busy_b;
  logic [15:0] rom_addr_b;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t tv[8];
  rom_access_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(8), .ROM_LATENCY(1)) dut_a (
    .in_clk(clk), .in_rst_p(rst), .in_req(req_a), .in_addr(addr_a), .out_ack(ack_a),
    .out_data(data_a), .out_grant_id(grant_a), .out_busy(busy_a), .out_rom_addr(rom_addr_a),
    .in_rom_data(rom_data_a));
  rom_access_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(8), .ROM_LATENCY(3)) dut_b (
    .in_clk(clk), .in_rst_p(rst), .in_req(req_b), .in_addr(addr_b), .out_ack(ack_b),
    .out_data(data_b), .out_grant_id(grant_b), .out_busy(busy_b), .out_rom_addr(rom_addr_b),
    .in_rom_data(rom_data_b));
  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction
  always @(posedge clk) rom_data_a <= rom_f(rom_addr_a);
  always @(posedge clk) begin
    rb1        <= rom_f(rom_addr_b);
    rb2        <= rb1;
    rom_data_b <= rb2;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack_a != 2'b00) begin
      chk("ack_a_onehot", 32'($onehot(ack_a)), 32'd1);
      if (q_a.size() == 0) chk("ack_a_unexpected", 32'(ack_a), 32'd0);
      else begin
        e = q_a.pop_front();
        chk("ack_a", 32'(ack_a), 32'(e.ack));
        chk("data_a", 32'(data_a), 32'(e.data));
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ack_b != 3'b000) begin
      chk("ack_b_onehot", 32'($onehot(ack_b)), 32'd1);
      if (q_b.size() == 0) chk("ack_b_unexpected", 32'(ack_b), 32'd0);
      else begin
        e = q_b.pop_front();
        chk("ack_b", 32'(ack_b), 32'(e.ack));
        chk("data_b", 32'(data_b), 32'(e.data));
      end
    end
  end
  task automatic wait_ack_a(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (ack_a == 2'b00 && k < 20);
  endtask
  task automatic wait_ack_b(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (ack_b == 3'b000 && k < 20);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k;
    int seen;
    tv[0] = '{2'b01, 16'h0010, 16'h0000, 1'b0};
    tv[1] = '{2'b10, 16'h0000, 16'h1234, 1'b1};
    tv[2] = '{2'b11, 16'h00FF, 16'hABCD, 1'b0};
    tv[3] = '{2'b11, 16'h0F0F, 16'h3C3C, 1'b1};
    tv[4] = '{2'b10, 16'h0001, 16'hFFFF, 1'b1};
    tv[5] = '{2'b11, 16'h1111, 16'h2222, 1'b0};
    tv[6] = '{2'b01, 16'h0000, 16'h9999, 1'b0};
    tv[7] = '{2'b11, 16'h8001, 16'h7FFE, 1'b1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_grant", 32'(grant_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_a  = tv[i].req;
      addr_a = {tv[i].a1, tv[i].a0};
      q_a.push_back('{tv[i].g ? 3'b010 : 3'b001, rom_f(tv[i].g ? tv[i].a1 : tv[i].a0)});
      @(negedge clk);
      chk("vec_grant", 32'(grant_a), 32'(tv[i].g));
      chk("vec_rom_addr", 32'(rom_addr_a), 32'(tv[i].g ? tv[i].a1 : tv[i].a0));
      chk("vec_busy", 32'(busy_a), 32'd1);
      wait_ack_a(k);
      chk("vec_latency", k, 32'd2);
      req_a = 2'b00;
      @(negedge clk);
      chk("vec_idle", 32'(busy_a), 32'd0);
    end
    // contention: both held, strict alternation starting at 0, one ack every 4 cycles
    @(negedge clk);
    req_a  = 2'b11;
    addr_a = {16'h5555, 16'h0AAA};
    for (int j = 0; j < 4; j++)
      q_a.push_back('{(j % 2) ? 3'b010 : 3'b001, rom_f((j % 2) ? 16'h5555 : 16'h0AAA)});
    for (int j = 0; j < 4; j++) begin
      wait_ack_a(k);
      chk("rr_spacing", k, (j == 0) ? 32'd3 : 32'd4);
    end
    req_a = 2'b00;
    @(negedge clk);
    // busy arrival and address change during WAIT
    @(negedge clk);
    req_a  = 2'b01;
    addr_a = {16'h0300, 16'h0100};
    q_a.push_back('{3'b001, rom_f(16'h0100)});
    q_a.push_back('{3'b010, rom_f(16'h0300)});
    @(negedge clk);
    addr_a[15:0] = 16'h0200;
    req_a = 2'b11;
    @(negedge clk);
    chk("busy_addr_hold", 32'(rom_addr_a), 32'h0100);
    wait_ack_a(k);
    chk("busy_latency0", k, 32'd1);
    req_a = 2'b10;
    @(negedge clk);
    chk("busy_idle_gap", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("busy_grant1", 32'(grant_a), 32'd1);
    chk("busy_rom_addr1", 32'(rom_addr_a), 32'h0300);
    wait_ack_a(k);
    chk("busy_latency1", k, 32'd2);
    req_a = 2'b00;
    @(negedge clk);
    // withdrawal during WAIT
    @(negedge clk);
    req_a  = 2'b01;
    addr_a = {16'h0000, 16'h0042};
    q_a.push_back('{3'b001, rom_f(16'h0042)});
    @(negedge clk);
    req_a = 2'b00;
    wait_ack_a(k);
    chk("wd_latency", k, 32'd2);
    @(negedge clk);
    chk("wd_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("wd_no_regrant", 32'(busy_a), 32'd0);
    // 3 requesters, latency 3, pointer wrap 2 -> 0
    @(negedge clk);
    req_b  = 3'b100;
    addr_b = {16'hFFFF, 16'h0000, 16'h0777};
    q_b.push_back('{3'b100, rom_f(16'hFFFF)});
    @(negedge clk);
    chk("b_grant2", 32'(grant_b), 32'd2);
    chk("b_rom_addr", 32'(rom_addr_b), 32'hFFFF);
    wait_ack_b(k);
    chk("b_latency", k, 32'd4);
    req_b = 3'b000;
    @(negedge clk);
    req_b = 3'b101;
    q_b.push_back('{3'b001, rom_f(16'h0777)});
    q_b.push_back('{3'b100, rom_f(16'hFFFF)});
    wait_ack_b(k);
    chk("b_wrap_latency", k, 32'd5);
    wait_ack_b(k);
    chk("b_spacing", k, 32'd6);
    req_b = 3'b000;
    @(negedge clk);
    // reset in the middle of a WAIT
    @(negedge clk);
    req_a  = 2'b01;
    addr_a = {16'h0000, 16'h0055};
    @(negedge clk);
    rst   = 1'b1;
    req_a = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mrst_ack", 32'(ack_a), 32'd0);
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("mrst_grant", 32'(grant_a), 32'd0);
    chk("mrst_data", 32'(data_a), 32'd0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack_a != 2'b00) seen++;
    end
    chk("mrst_no_ack", seen, 32'd0);
    req_a  = 2'b11;
    addr_a = {16'h4444, 16'h3333};
    q_a.push_back('{3'b001, rom_f(16'h3333)});
    wait_ack_a(k);
    chk("mrst_prio0", k, 32'd3);
    req_a = 2'b00;
    repeat (2) @(negedge clk);
    chk("q_a_drained", q_a.size(), 32'd0);
    chk("q_b_drained", q_b.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
